// File: rtl/wbdbgbus_testmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wbdbgbus_testmem_pkg
// Purpose  : Shared types and helpers for the wbdbgbus test memory slave.
// Revision : 1.0 - initial release
// ============================================================================
package wbdbgbus_testmem_pkg;

    localparam int MAX_LATENCY = 4;
    localparam int RESP_DATA_W = 128;
    localparam int RESP_SEL_W  = RESP_DATA_W / 8;

    // Sized for the widest supported bus; narrower instances zero-extend.
    typedef struct packed {
        logic                   valid;
        logic                   err;
        logic [RESP_DATA_W-1:0] data;
    } resp_t;

    function automatic logic [RESP_DATA_W-1:0] byte_merge(
        input logic [RESP_DATA_W-1:0] old_word,
        input logic [RESP_DATA_W-1:0] new_word,
        input logic [RESP_SEL_W-1:0]  sel
    );
        logic [RESP_DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < RESP_SEL_W; b++) begin
            if (sel[b]) begin
                merged[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wbdbgbus_resp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : wbdbgbus_resp_pipe
// Purpose  : LATENCY-stage response shift register with flush and reset.
// Revision : 1.0 - initial release
// ============================================================================
module wbdbgbus_resp_pipe
    import wbdbgbus_testmem_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_flush,
    input  resp_t i_resp,
    output resp_t o_resp
);

    resp_t r_stage [LATENCY];

    // Flush only kills valid bits; stale data is masked downstream.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0]       <= i_resp;
            r_stage[0].valid <= i_resp.valid & ~i_flush;
            for (int i = 1; i < LATENCY; i++) begin
                r_stage[i]       <= r_stage[i-1];
                r_stage[i].valid <= r_stage[i-1].valid & ~i_flush;
            end
        end
    end

    assign o_resp = r_stage[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/wbdbgbus_testmem.sv
`default_nettype none
// ============================================================================
// Module   : wbdbgbus_testmem
// Purpose  : Parametrised pipelined Wishbone memory target with fault hooks.
// Revision : 1.0 - initial release
// ============================================================================
module wbdbgbus_testmem
    import wbdbgbus_testmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 128,
    parameter int LATENCY     = 1,
    parameter int OOR_ERR     = 0,
    parameter int STALL_EVERY = 0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_wb_cyc,
    input  logic                i_wb_stb,
    input  logic                i_wb_we,
    input  logic [ADDR_W-1:0]   i_wb_addr,
    input  logic [DATA_W-1:0]   i_wb_data,
    input  logic [DATA_W/8-1:0] i_wb_sel,
    output logic                o_wb_ack,
    output logic                o_wb_err,
    output logic                o_wb_stall,
    output logic [DATA_W-1:0]   o_wb_data,
    input  logic                i_force_stall,
    input  logic                i_force_error,
    output logic [15:0]         o_resp_count
);

    localparam int                c_IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                c_LAT     = (LATENCY > MAX_LATENCY) ? MAX_LATENCY :
                                              (LATENCY < 1) ? 1 : LATENCY;
    localparam logic [ADDR_W-1:0] c_DEPTH_A = ADDR_W'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [15:0]        r_resp_count;
    logic               w_gen_stall;
    logic               w_accept;
    logic               w_in_range;
    logic               w_resp_err;
    logic               w_do_write;
    logic [c_IDX_W-1:0] w_idx;
    logic [DATA_W-1:0]  w_rd_word;
    logic [DATA_W-1:0]  w_merged;
    resp_t              w_push;
    resp_t              w_out;
    logic               w_unused_resp;

    if (STALL_EVERY >= 2) begin : g_stall_gen
        localparam int                 c_CNT_W = $clog2(STALL_EVERY);
        localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(STALL_EVERY - 1);
        logic [c_CNT_W-1:0] r_stall_cnt;

        always_ff @(posedge i_clk) begin
            if (!i_rst_n || !i_wb_cyc || r_stall_cnt == c_LAST) begin
                r_stall_cnt <= '0;
            end else begin
                r_stall_cnt <= r_stall_cnt + c_CNT_W'(1);
            end
        end
        assign w_gen_stall = (r_stall_cnt == c_LAST);
    end else begin : g_no_stall
        assign w_gen_stall = 1'b0;
    end

    assign o_wb_stall = i_force_stall | w_gen_stall;
    // Nothing is accepted while reset is held, so no RAM write can slip in.
    assign w_accept   = i_rst_n & i_wb_cyc & i_wb_stb & ~o_wb_stall;
    assign w_in_range = (i_wb_addr < c_DEPTH_A);
    assign w_idx      = i_wb_addr[c_IDX_W-1:0];
    assign w_rd_word  = r_mem[w_idx];
    assign w_resp_err = i_force_error | (~w_in_range & (OOR_ERR != 0));
    assign w_do_write = w_accept & i_wb_we & w_in_range & ~i_force_error;
    assign w_merged   = DATA_W'(byte_merge(RESP_DATA_W'(w_rd_word),
                                           RESP_DATA_W'(i_wb_data),
                                           RESP_SEL_W'(i_wb_sel)));

    always_ff @(posedge i_clk) begin
        if (w_do_write) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    always_comb begin
        w_push       = '0;
        w_push.valid = w_accept;
        w_push.err   = w_resp_err;
        if (w_accept && !i_wb_we && w_in_range && !w_resp_err) begin
            w_push.data = RESP_DATA_W'(w_rd_word);
        end
    end

    wbdbgbus_resp_pipe #(
        .LATENCY (c_LAT)
    ) u_resp_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (~i_wb_cyc),
        .i_resp  (w_push),
        .o_resp  (w_out)
    );

    // Gating with cyc guarantees no response escapes once the master aborts.
    assign o_wb_ack      = w_out.valid & ~w_out.err & i_wb_cyc;
    assign o_wb_err      = w_out.valid &  w_out.err & i_wb_cyc;
    assign o_wb_data     = o_wb_ack ? w_out.data[DATA_W-1:0] : '0;
    assign w_unused_resp = ^w_out.data;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_resp_count <= '0;
        end else if (o_wb_ack || o_wb_err) begin
            r_resp_count <= r_resp_count + 16'd1;
        end
    end

    assign o_resp_count = r_resp_count;

endmodule
`default_nettype wire
